// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue/response controller placed directly in front of the 32-bit ALU.
// It accepts one operation at a time over a valid/ready request handshake.
// It then drives registered operands and opcode into the ALU and holds them
// for one cycle, or for MOD_LATENCY extra cycles on the multi-cycle mod op
// (opcode 3'b111). Finally it captures the ALU result into a response
// register, which is offered over a second valid/ready handshake.
//
// Optional feature:
//   ALU_ISSUE_ZERO_FLAG_EN - when defined, adds output rsp_zero. This flag is
//                            registered at capture as (alu_result == 0).
//
// Parameters:
//   MOD_LATENCY  extra hold cycles for the mod op (legal range 1..255)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    request present
//   req_ready    controller can accept a request (IDLE and not in reset)
//   req_a/req_b  request operands
//   req_op       request opcode
//   alu_a/alu_b  registered operands to ALU
//   alu_op       registered opcode to ALU (3'b000 outside EXEC)
//   alu_result   ALU result
//   rsp_valid    response present (RESP state)
//   rsp_ready    consumer accepts response
//   rsp_result   captured ALU result
//   rsp_op       opcode that produced rsp_result
//   rsp_zero     (ALU_ISSUE_ZERO_FLAG_EN only) captured result was zero
//   busy         high in EXEC or RESP
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int unsigned MOD_LATENCY = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_op,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    output logic        rsp_zero,
`endif
    output logic        busy
);

    localparam int unsigned DATA_W  = 32;
    localparam logic [2:0]  OP_MOD  = 3'b111;
    localparam logic [2:0]  OP_IDLE = 3'b000;
    localparam logic [7:0]  MOD_CNT = 8'(MOD_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [2:0]        alu_op_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic [2:0]        rsp_op_q;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic              rsp_zero_q;
`endif

    // Handshake flags depend on state only, so no combinational path runs
    // from req_valid or rsp_ready to any output. req_ready is also masked
    // by rst. The async reset already forces IDLE, and without the mask
    // the controller would advertise readiness while it is held in reset.
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    assign rsp_zero   = rsp_zero_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_IDLE;
            rsp_result_q <= '0;
            rsp_op_q     <= OP_IDLE;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            rsp_zero_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_a_q  <= req_a;
                        alu_b_q  <= req_b;
                        alu_op_q <= req_op;
                        rsp_op_q <= req_op;
                        cnt      <= (req_op == OP_MOD) ? MOD_CNT : 8'd0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        rsp_result_q <= alu_result;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                        rsp_zero_q   <= (alu_result == '0);
`endif
                        // Dropping the opcode here ensures the ALU sees a
                        // non-mod cycle between two mod starts. The operands
                        // are left as they are because only the opcode
                        // starts an ALU operation.
                        alu_op_q     <= OP_IDLE;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    alu_op_q <= OP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int unsigned MOD_LATENCY = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_op;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic        rsp_zero;
`endif
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MOD_LATENCY(MOD_LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .busy       (busy)
    );

    // Behavioural ALU placed downstream of the controller
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: alu_result = alu_a ^ alu_b;
            3'b011: alu_result = ~(alu_a | alu_b);
            3'b100: alu_result = {31'b0, (alu_a < alu_b)};
            3'b101: alu_result = alu_a + alu_b;
            3'b110: alu_result = alu_a - alu_b;
            3'b111: alu_result = (alu_b == 32'h0) ? 32'h0 : (alu_a % alu_b);
            default: alu_result = 32'h0;
        endcase
    end

    // Advance one clock and settle 1 ns past the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and let the next edge accept it (controller idle)
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a = a;
        req_b = b;
        req_op = op;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_a = 32'h0;
        req_b = 32'h0;
        req_op = 3'b000;
        #3;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req_ready got %b want 0", req_ready);
        end
        tests_run++;
        if ({rsp_valid, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_flags got %b want 00", {rsp_valid, busy});
        end
        tests_run++;
        if ({alu_a, alu_b, alu_op, rsp_result, rsp_op} !== 102'h0) begin
            tests_failed++;
            $display("FAIL reset_data got %h want 0", {alu_a, alu_b, alu_op, rsp_result, rsp_op});
        end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        tests_run++;
        if (rsp_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_zero got %b want 0", rsp_zero);
        end
`endif
        step();
        rst = 1'b0;
        step();
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_add();
        rsp_ready = 1'b1;
        issue(32'h7, 32'h5, 3'b101);
        tests_run++;
        if ({alu_a, alu_b, alu_op} !== {32'h7, 32'h5, 3'b101}) begin
            tests_failed++;
            $display("FAIL add_exec_alu got %h/%h/%b want 7/5/101", alu_a, alu_b, alu_op);
        end
        tests_run++;
        if ({rsp_valid, busy, req_ready} !== 3'b010) begin
            tests_failed++;
            $display("FAIL add_exec_flags got %b want 010", {rsp_valid, busy, req_ready});
        end
        step();
        tests_run++;
        if ({rsp_valid, rsp_result, rsp_op} !== {1'b1, 32'hC, 3'b101}) begin
            tests_failed++;
            $display("FAIL add_rsp got v=%b r=%h op=%b want v=1 r=c op=101", rsp_valid, rsp_result, rsp_op);
        end
        tests_run++;
        if ({alu_op, alu_a} !== {3'b000, 32'h7}) begin
            tests_failed++;
            $display("FAIL add_resp_alu got op=%b a=%h want op=000 a=7", alu_op, alu_a);
        end
        step();
        tests_run++;
        if ({rsp_valid, busy, req_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL add_done_flags got %b want 001", {rsp_valid, busy, req_ready});
        end
    endtask

    task automatic test_mod();
        int k;
        int ops;
        rsp_ready = 1'b1;
        issue(32'd17, 32'd5, 3'b111);
        k = 0;
        ops = 0;
        while (rsp_valid !== 1'b1 && k < 100) begin
            if (alu_op === 3'b111) ops++;
            step();
            k++;
        end
        tests_run++;
        if (k !== MOD_LATENCY + 1) begin
            tests_failed++;
            $display("FAIL mod_latency got %0d edges want %0d", k, MOD_LATENCY + 1);
        end
        tests_run++;
        if (ops !== MOD_LATENCY + 1) begin
            tests_failed++;
            $display("FAIL mod_hold got %0d cycles want %0d", ops, MOD_LATENCY + 1);
        end
        tests_run++;
        if ({rsp_result, rsp_op, alu_op} !== {32'd2, 3'b111, 3'b000}) begin
            tests_failed++;
            $display("FAIL mod_rsp got r=%h op=%b alu_op=%b want 2/111/000", rsp_result, rsp_op, alu_op);
        end
        // Second mod presented while in RESP; it must wait for IDLE
        req_a = 32'd29;
        req_b = 32'd8;
        req_op = 3'b111;
        req_valid = 1'b1;
        step();
        tests_run++;
        if ({alu_op, req_ready, rsp_valid} !== {3'b000, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL mod_gap got op=%b rdy=%b v=%b want 000/1/0", alu_op, req_ready, rsp_valid);
        end
        step();
        req_valid = 1'b0;
        tests_run++;
        if ({alu_op, alu_a} !== {3'b111, 32'd29}) begin
            tests_failed++;
            $display("FAIL mod2_accept got op=%b a=%h want 111/1d", alu_op, alu_a);
        end
        k = 0;
        while (rsp_valid !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        tests_run++;
        if ({k, rsp_result} !== {MOD_LATENCY + 1, 32'd5}) begin
            tests_failed++;
            $display("FAIL mod2_rsp got k=%0d r=%h want k=%0d r=5", k, rsp_result, MOD_LATENCY + 1);
        end
        step();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000);
        // Pending OR request while the response is stalled
        req_a = 32'h1;
        req_b = 32'h2;
        req_op = 3'b001;
        req_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({rsp_valid, req_ready, busy, rsp_result, rsp_op} !== {3'b101, 32'hF000_F000, 3'b000}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d] got v=%b rdy=%b busy=%b r=%h op=%b want 1/0/1/f000f000/000",
                         i, rsp_valid, req_ready, busy, rsp_result, rsp_op);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        tests_run++;
        if ({rsp_valid, busy, alu_op} !== {2'b00, 3'b000}) begin
            tests_failed++;
            $display("FAIL bp_release got v=%b busy=%b op=%b want 0/0/000", rsp_valid, busy, alu_op);
        end
        step();
        req_valid = 1'b0;
        tests_run++;
        if ({alu_op, alu_a, alu_b} !== {3'b001, 32'h1, 32'h2}) begin
            tests_failed++;
            $display("FAIL bp_pending_accept got op=%b a=%h b=%h want 001/1/2", alu_op, alu_a, alu_b);
        end
        step();
        tests_run++;
        if ({rsp_valid, rsp_result} !== {1'b1, 32'h3}) begin
            tests_failed++;
            $display("FAIL bp_pending_rsp got v=%b r=%h want 1/3", rsp_valid, rsp_result);
        end
        step();
    endtask

    task automatic test_reset_mid_mod();
        logic seen;
        rsp_ready = 1'b1;
        issue(32'd100, 32'd7, 3'b111);
        repeat (10) step();
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({alu_a, alu_b, alu_op, rsp_result, rsp_op} !== 102'h0) begin
            tests_failed++;
            $display("FAIL midrst_data got %h want 0", {alu_a, alu_b, alu_op, rsp_result, rsp_op});
        end
        tests_run++;
        if ({rsp_valid, busy, req_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL midrst_flags got %b want 000", {rsp_valid, busy, req_ready});
        end
        #2;
        rst = 1'b0;
        seen = 1'b0;
        repeat (MOD_LATENCY + 5) begin
            step();
            if (rsp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_no_rsp got activity=%b want 0", seen);
        end
        issue(32'h1, 32'h2, 3'b001);
        step();
        tests_run++;
        if ({rsp_valid, rsp_result, rsp_op} !== {1'b1, 32'h3, 3'b001}) begin
            tests_failed++;
            $display("FAIL midrst_or got v=%b r=%h op=%b want 1/3/001", rsp_valid, rsp_result, rsp_op);
        end
        step();
    endtask

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    task automatic test_zero_flag();
        rsp_ready = 1'b1;
        issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b010);
        step();
        tests_run++;
        if ({rsp_valid, rsp_result, rsp_zero} !== {1'b1, 32'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL zero_xor got v=%b r=%h z=%b want 1/0/1", rsp_valid, rsp_result, rsp_zero);
        end
        step();
        issue(32'd3, 32'd1, 3'b110);
        step();
        tests_run++;
        if ({rsp_valid, rsp_result, rsp_zero} !== {1'b1, 32'h2, 1'b0}) begin
            tests_failed++;
            $display("FAIL zero_sub got v=%b r=%h z=%b want 1/2/0", rsp_valid, rsp_result, rsp_zero);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_mod();
        test_backpressure();
        test_reset_mid_mod();
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
